context_switch_sequencer: RTL and testbench
===========================================

// Module: context_switch_sequencer
// PURPOSE
//  Saves and restores the integer register file (x1..x31) to/from data memory on an OS context switch.
//  It sits beside the decode stage and owns both register-file ports while active.
//  It stalls the pipeline, waits for it to drain, streams 31 stores (save) then 31 loads (restore), and releases the ports.
//  Outside a switch it is transparent: pipeline read/write requests pass straight through to reg_file.
// PARAMETERS
//  DATA_WIDTH  32  register / memory word width
//  ADDR_WIDTH  32  data-memory byte address width
//  NUM_REGS    32  architectural registers; x0 is never saved or restored
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  cs_req           in   1   start a switch; sampled only in IDLE
//  save_base        in   32  byte base of outgoing context; captured on accept
//  restore_base     in   32  byte base of incoming context; captured on accept
//  pipe_empty       in   1   no instruction past decode is in flight
//  pipe_stall       out  1   freeze fetch/decode
//  cs_busy          out  1   sequencer owns the register-file ports
//  cs_done          out  1   one-cycle pulse when the switch completes
//  pipe_rd_addr     in   5   pipeline rs1 address (pass-through)
//  pipe_wr_en       in   1   pipeline write enable (pass-through)
//  pipe_wr_addr     in   5   pipeline write address
//  pipe_wr_data     in   32  pipeline write data
//  rf_rd_addr       out  5   to reg_file read port 1
//  rf_rd_data       in   32  from reg_file read port 1 (combinational read)
//  rf_wr_en         out  1   to reg_file
//  rf_wr_addr       out  5   to reg_file
//  rf_wr_data       out  32  to reg_file
//  mem_read         out  1   data-memory read request
//  mem_write        out  1   data-memory write request
//  mem_addr         out  32  byte address
//  mem_wdata        out  32  store data
//  mem_rdata        in   32  load data; valid in the completing cycle
//  mem_busy         in   1   access completes in a cycle where the request is high and mem_busy is low
// BEHAVIOUR
//  Reset: state=IDLE; idx=1; pipe_stall, cs_busy, cs_done, mem_read, mem_write and rf_wr_en are 0; mem_addr and mem_wdata are 0.
//  FSM states: IDLE -> DRAIN -> SAVE -> RESTORE -> DONE -> IDLE.
//  IDLE: ports pass through (rf_rd_addr=pipe_rd_addr; rf_wr_*=pipe_wr_*).
//   cs_req=1 captures both bases, sets pipe_stall=1 and goes to DRAIN.
//  DRAIN: pass-through stays active so in-flight writebacks land. When pipe_empty=1, go to SAVE with idx=1 and cs_busy=1.
//  SAVE: rf_rd_addr=idx; mem_write=1; mem_addr=save_base+4*idx; mem_wdata=rf_rd_data.
//   On completion: idx++. After idx=31 completes, set idx=1 and go to RESTORE.
//  RESTORE: mem_read=1; mem_addr=restore_base+4*idx.
//   On completion: rf_wr_en=1, rf_wr_addr=idx, rf_wr_data=mem_rdata in that same cycle; idx++. After idx=31 completes, go to DONE.
//  DONE: cs_done=1 for one cycle; pipe_stall and cs_busy drop on the transition to IDLE.
//  Latency with mem_busy tied 0 and pipe_empty already 1: accept to cs_done = 1+31+31+1 = 64 cycles.
//  Byte offset base+0 (x0 slot) is never accessed. Address adds are modulo 2^32; no alignment check is made.
//  While cs_busy=1: pipe_wr_en is ignored (never reaches reg_file) and pipe_rd_addr is ignored.
//  cs_req while not in IDLE is ignored, and no request is queued.
//  mem_busy held high stalls the sequencer indefinitely; request, address and data stay stable.
//  Reset mid-switch returns to IDLE immediately. The register file is left partially restored; software must retry.
// CONFIGURATION
//  CS_DIRTY_SKIP_EN defined: a 31-bit dirty mask sets bit i on any reg_file write to xi outside a switch.
//   The mask is cleared when RESTORE completes. SAVE skips clean registers at 1 cycle each, with no mem_write.
//   The mask resets to all-ones so the first switch saves everything.
//  CS_DIRTY_SKIP_EN undefined: every register x1..x31 is always saved; no mask logic is present.
// STRUCTURE
//  Shared header cs_defs.vh: FSM state encodings (IDLE=0, DRAIN=1, SAVE=2, RESTORE=3, DONE=4);
//   REG_IDX_W=5, WORD_BYTES=4, FIRST_REG=1, LAST_REG=31.
//  One sub-module, cs_dirty_tracker (mask register plus a skip query), instantiated only under CS_DIRTY_SKIP_EN.
//  Address generation, the FSM and the port muxes stay in the top module.
// TESTING
//  1 Pass-through: IDLE, pipe_wr_en=1 addr=5 data=0xA5 -> rf_wr_en=1 addr=5 data=0xA5 in the same cycle; pipe_stall=0.
//  2 Full switch: regs xi=i, save_base=0x1000, restore_base=0x2000 holding 0x100+i, mem_busy=0, pipe_empty=1
//    -> mem[0x1004..0x107C]=1..31; then xi=0x100+i; cs_done at cycle 64; x0 untouched.
//  3 Drain/backpressure: pipe_empty low for 3 cycles -> first mem_write 4 cycles after accept.
//    mem_busy high 2 cycles on idx=7 -> mem_addr=0x101C and mem_wdata stay stable 3 cycles.
//  4 Collisions: cs_req during SAVE -> ignored, exactly one cs_done.
//    pipe_wr_en=1 during RESTORE -> rf_wr_addr/data come from the sequencer only.
//  5 Reset at RESTORE idx=10 -> next cycle IDLE, pipe_stall=0, cs_busy=0, no cs_done.
//    A new cs_req then starts a clean switch.
//  6 CS_DIRTY_SKIP_EN: after one switch, write only x3 and x17, switch again
//    -> exactly 2 mem_write completions (0x100C, 0x1044); SAVE lasts 31 cycles.

Source files
------------

// File: rtl/context_switch_sequencer_pkg.sv
// rtl/context_switch_sequencer_pkg.sv - shared FSM encoding and register-index constants for the context-switch sequencer
package context_switch_sequencer_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int WORD_BYTES = 4;
  localparam logic [REG_IDX_W-1:0] FIRST_REG = 5'd1;
  localparam logic [REG_IDX_W-1:0] LAST_REG  = 5'd31;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_DRAIN   = 3'd1,
    CS_SAVE    = 3'd2,
    CS_RESTORE = 3'd3,
    CS_DONE    = 3'd4
  } cs_state_e;

endpackage

// File: rtl/cs_dirty_tracker.sv
// rtl/cs_dirty_tracker.sv - per-register dirty mask with a skip query for the save phase
// Built only when CS_DIRTY_SKIP_EN is defined.
`ifdef CS_DIRTY_SKIP_EN
module cs_dirty_tracker
  import context_switch_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clear,
  input  logic [REG_IDX_W-1:0] i_query_idx,
  output logic                 o_skip
);

  // Starts all-ones so the very first switch saves every register.
  logic [NUM_REGS-1:1] r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '1;
    end else if (i_clear) begin
      r_mask <= '0;
    end else if (i_set_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_set_idx == REG_IDX_W'(i)) begin
          r_mask[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_skip = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i_query_idx == REG_IDX_W'(i)) begin
        o_skip = !r_mask[i];
      end
    end
  end

endmodule
`endif

// File: rtl/context_switch_sequencer.sv
// rtl/context_switch_sequencer.sv - saves x1..x31 to memory and restores them on an OS context switch
// Optional CS_DIRTY_SKIP_EN: registers not written since the last switch are skipped during save.
module context_switch_sequencer
  import context_switch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_req,
  input  logic [ADDR_WIDTH-1:0] save_base,
  input  logic [ADDR_WIDTH-1:0] restore_base,
  input  logic                  pipe_empty,
  output logic                  pipe_stall,
  output logic                  cs_busy,
  output logic                  cs_done,
  input  logic [REG_IDX_W-1:0]  pipe_rd_addr,
  input  logic                  pipe_wr_en,
  input  logic [REG_IDX_W-1:0]  pipe_wr_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wr_data,
  output logic [REG_IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  rf_wr_en,
  output logic [REG_IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_busy
);

  localparam logic [REG_IDX_W-1:0] L_LAST_IDX =
    (NUM_REGS - 1 > int'(LAST_REG)) ? LAST_REG : REG_IDX_W'(NUM_REGS - 1);

  cs_state_e             r_state;
  cs_state_e             w_next;
  logic [REG_IDX_W-1:0]  r_idx;
  logic [ADDR_WIDTH-1:0] r_save_base;
  logic [ADDR_WIDTH-1:0] r_restore_base;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_accept;
  logic                  w_skip;
  logic                  w_step;
  logic                  w_last_step;

  assign w_accept    = (r_state == CS_IDLE) && cs_req;
  assign w_offset    = ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(WORD_BYTES);
  // A skipped (clean) register advances in one cycle regardless of mem_busy.
  assign w_step      = ((r_state == CS_SAVE) && (w_skip || !mem_busy)) ||
                       ((r_state == CS_RESTORE) && !mem_busy);
  assign w_last_step = w_step && (r_idx == L_LAST_IDX);

`ifdef CS_DIRTY_SKIP_EN
  logic w_track_wr;
  logic w_track_clr;

  assign w_track_wr  = rf_wr_en && ((r_state == CS_IDLE) || (r_state == CS_DRAIN));
  assign w_track_clr = w_last_step && (r_state == CS_RESTORE);

  cs_dirty_tracker #(
    .NUM_REGS(NUM_REGS)
  ) u_dirty (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (w_track_wr),
    .i_set_idx   (rf_wr_addr),
    .i_clear     (w_track_clr),
    .i_query_idx (r_idx),
    .o_skip      (w_skip)
  );
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx          <= FIRST_REG;
      r_save_base    <= '0;
      r_restore_base <= '0;
    end else if (w_accept) begin
      r_idx          <= FIRST_REG;
      r_save_base    <= save_base;
      r_restore_base <= restore_base;
    end else if (w_step) begin
      r_idx <= w_last_step ? FIRST_REG : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CS_IDLE:    if (cs_req)      w_next = CS_DRAIN;
      CS_DRAIN:   if (pipe_empty)  w_next = CS_SAVE;
      CS_SAVE:    if (w_last_step) w_next = CS_RESTORE;
      CS_RESTORE: if (w_last_step) w_next = CS_DONE;
      CS_DONE:                     w_next = CS_IDLE;
      default:                     w_next = CS_IDLE;
    endcase
  end

  // DRAIN keeps the pass-through so writebacks already in flight still land.
  always_comb begin
    pipe_stall = (r_state != CS_IDLE);
    cs_busy    = (r_state == CS_SAVE) || (r_state == CS_RESTORE) || (r_state == CS_DONE);
    cs_done    = (r_state == CS_DONE);
    rf_rd_addr = r_idx;
    rf_wr_en   = 1'b0;
    rf_wr_addr = r_idx;
    rf_wr_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      CS_IDLE, CS_DRAIN: begin
        rf_rd_addr = pipe_rd_addr;
        rf_wr_en   = pipe_wr_en;
        rf_wr_addr = pipe_wr_addr;
        rf_wr_data = pipe_wr_data;
      end
      CS_SAVE: begin
        mem_write = !w_skip;
        mem_addr  = r_save_base + w_offset;
        mem_wdata = rf_rd_data;
      end
      CS_RESTORE: begin
        mem_read   = 1'b1;
        mem_addr   = r_restore_base + w_offset;
        rf_wr_en   = !mem_busy;
        rf_wr_data = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_context_switch_sequencer.sv
// tb/tb_context_switch_sequencer.sv - scoreboard bench for context_switch_sequencer
// Define CS_DIRTY_SKIP_EN to add the dirty-skip scenario.
`timescale 1ns/1ps
module tb_context_switch_sequencer;

  logic        clk = 1'b0;
  logic        reset, cs_req, pipe_empty, pipe_wr_en, mem_busy;
  logic [31:0] save_base, restore_base, pipe_wr_data, rf_rd_data, rf_wr_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  pipe_rd_addr, pipe_wr_addr, rf_rd_addr, rf_wr_addr;
  logic        pipe_stall, cs_busy, cs_done, rf_wr_en, mem_read, mem_write;

  logic [31:0] rf  [0:31];
  logic [31:0] mem [0:4095];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_st_a[$], exp_st_d[$], exp_rf_a[$], exp_rf_d[$];
  logic [31:0] mon_a, mon_d;

  int   m_done_cyc, m_n_done, m_first_wr, m_stable, m_save_cyc, m_stall_after;
  logic m_stall1, m_busy1;

  always #5 clk = ~clk;

  context_switch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cs_req       (cs_req),
    .save_base    (save_base),
    .restore_base (restore_base),
    .pipe_empty   (pipe_empty),
    .pipe_stall   (pipe_stall),
    .cs_busy      (cs_busy),
    .cs_done      (cs_done),
    .pipe_rd_addr (pipe_rd_addr),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_wr_addr (pipe_wr_addr),
    .pipe_wr_data (pipe_wr_data),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy)
  );

  assign rf_rd_data = rf[rf_rd_addr];
  assign mem_rdata  = mem_read ? mem[mem_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_addr] = rf_wr_data;
    if (mem_write && !mem_busy) mem[mem_addr[13:2]] = mem_wdata;
  end

  // Scoreboard: every completed store and every sequencer register write is popped and compared.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_write && !mem_busy) begin
        total++;
        if (exp_st_a.size() == 0) begin
          bad++;
          $display("FAIL store_extra got addr=%h data=%h expected no store", mem_addr, mem_wdata);
        end else begin
          mon_a = exp_st_a.pop_front();
          mon_d = exp_st_d.pop_front();
          if (mem_addr !== mon_a || mem_wdata !== mon_d) begin
            bad++;
            $display("FAIL store got addr=%h data=%h expected addr=%h data=%h", mem_addr, mem_wdata, mon_a, mon_d);
          end
        end
      end
      if (cs_busy && rf_wr_en) begin
        total++;
        if (exp_rf_a.size() == 0) begin
          bad++;
          $display("FAIL restore_extra got x%0d=%h expected no write", rf_wr_addr, rf_wr_data);
        end else begin
          mon_a = exp_rf_a.pop_front();
          mon_d = exp_rf_d.pop_front();
          if ({27'd0, rf_wr_addr} !== mon_a || rf_wr_data !== mon_d) begin
            bad++;
            $display("FAIL restore got x%0d=%h expected x%0d=%h", rf_wr_addr, rf_wr_data, mon_a, mon_d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs(input logic [31:0] base);
    for (int i = 1; i < 32; i++) begin
      tick();
      pipe_wr_en   = 1'b1;
      pipe_wr_addr = 5'(i);
      pipe_wr_data = base + 32'(i);
    end
    tick();
    pipe_wr_en = 1'b0;
  endtask

  // Fills the incoming context in memory and queues the expected stores and restores.
  task automatic prep_switch(input logic [31:0] sb, rb, sval, rval);
    mem[int'(sb[13:2])] = 32'hDEADBEEF;
    mem[int'(rb[13:2])] = 32'hCAFEF00D;
    for (int i = 1; i < 32; i++) begin
      mem[int'(rb[13:2]) + i] = rval + 32'(i);
      exp_st_a.push_back(sb + 32'(4 * i));
      exp_st_d.push_back(sval + 32'(i));
      exp_rf_a.push_back(32'(i));
      exp_rf_d.push_back(rval + 32'(i));
    end
  endtask

  task automatic run_switch(input logic [31:0] sb, rb, input int empty_delay,
                            input logic [31:0] busy_addr, busy_data, input int busy_len,
                            input int req_cyc, input int wr_lo, input int wr_hi);
    int busy_left;
    bit busy_used;
    busy_left = 0; busy_used = 0;
    m_done_cyc = -1; m_n_done = 0; m_first_wr = -1; m_stable = 0;
    m_save_cyc = 0; m_stall_after = 0; m_stall1 = 1'b0; m_busy1 = 1'b0;
    tick();
    cs_req = 1'b1; save_base = sb; restore_base = rb;
    pipe_empty = (empty_delay == 0); mem_busy = 1'b0; pipe_wr_en = 1'b0;
    for (int c = 1; c < 300; c++) begin
      tick();
      cs_req = (c == req_cyc);
      if (c == req_cyc) begin save_base = 32'h3000; restore_base = 32'h3800; end
      pipe_empty   = (c >= empty_delay);
      pipe_wr_en   = (c >= wr_lo) && (c <= wr_hi);
      pipe_wr_addr = 5'd2;
      pipe_wr_data = 32'h0BAD;
      mem_busy     = 1'b0;
      #1;
      if (mem_write && mem_addr == busy_addr && !busy_used) begin busy_used = 1; busy_left = busy_len; end
      if (busy_left > 0) begin mem_busy = 1'b1; busy_left--; end
      #1;
      if (c == 1) begin m_stall1 = pipe_stall; m_busy1 = cs_busy; end
      if (mem_write && m_first_wr < 0) m_first_wr = c;
      if (mem_write && mem_addr == busy_addr && mem_wdata == busy_data) m_stable++;
      if (cs_busy && !mem_read && !cs_done) m_save_cyc++;
      if (cs_done) begin m_n_done++; if (m_done_cyc < 0) m_done_cyc = c; end
      if (m_done_cyc >= 0 && c > m_done_cyc && pipe_stall) m_stall_after++;
      if (m_done_cyc >= 0 && c >= m_done_cyc + 6) break;
    end
    cs_req = 1'b0; pipe_wr_en = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_pipe_stall got %b expected 0", pipe_stall); end
    total++; if (cs_busy !== 1'b0) begin bad++; $display("FAIL reset_cs_busy got %b expected 0", cs_busy); end
    total++; if (cs_done !== 1'b0) begin bad++; $display("FAIL reset_cs_done got %b expected 0", cs_done); end
    total++; if ({mem_read, mem_write, rf_wr_en} !== 3'b000) begin bad++; $display("FAIL reset_strobes got %b expected 000", {mem_read, mem_write, rf_wr_en}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_bus got %h/%h expected 0/0", mem_addr, mem_wdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pass_through();
    tick();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'hA5; pipe_rd_addr = 5'd9;
    #1;
    total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hA5) begin
      bad++; $display("FAIL pass_write got en=%b x%0d=%h expected en=1 x5=a5", rf_wr_en, rf_wr_addr, rf_wr_data); end
    total++; if (rf_rd_addr !== 5'd9) begin bad++; $display("FAIL pass_read got %0d expected 9", rf_rd_addr); end
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL pass_stall got %b expected 0", pipe_stall); end
    tick();
    pipe_wr_en = 1'b0;
    total++; if (rf[5] !== 32'hA5) begin bad++; $display("FAIL pass_landed got %h expected a5", rf[5]); end
  endtask

  task automatic test_full_switch();
    load_regs(32'h0);
    prep_switch(32'h1000, 32'h2000, 32'h0, 32'h100);
    run_switch(32'h1000, 32'h2000, 0, 32'hFFFFFFFF, 32'h0, 0, -1, -1, -1);
    total++; if (m_done_cyc != 64) begin bad++; $display("FAIL full_latency got %0d expected 64", m_done_cyc); end
    total++; if (m_n_done != 1) begin bad++; $display("FAIL full_done_count got %0d expected 1", m_n_done); end
    total++; if (m_first_wr != 2) begin bad++; $display("FAIL full_first_store got %0d expected 2", m_first_wr); end
    total++; if (m_stall1 !== 1'b1 || m_busy1 !== 1'b0) begin bad++; $display("FAIL full_drain_flags got stall=%b busy=%b expected 1/0", m_stall1, m_busy1); end
    total++; if (m_stall_after != 0) begin bad++; $display("FAIL full_release got %0d stalled cycles expected 0", m_stall_after); end
    total++; if (exp_st_a.size() != 0 || exp_rf_a.size() != 0) begin bad++; $display("FAIL full_drained got %0d/%0d left expected 0/0", exp_st_a.size(), exp_rf_a.size()); end
    total++; if (mem[32'h1000 >> 2] !== 32'hDEADBEEF) begin bad++; $display("FAIL full_x0_slot got %h expected deadbeef", mem[32'h1000 >> 2]); end
    total++; if (mem[32'h107C >> 2] !== 32'd31) begin bad++; $display("FAIL full_mem_x31 got %h expected 1f", mem[32'h107C >> 2]); end
    total++; if (rf[0] !== 32'h0) begin bad++; $display("FAIL full_x0 got %h expected 0", rf[0]); end
    for (int i = 1; i < 32; i++) begin
      total++; if (rf[i] !== 32'h100 + 32'(i)) begin bad++; $display("FAIL full_rf x%0d got %h expected %h", i, rf[i], 32'h100 + 32'(i)); end
    end
  endtask

  task automatic test_drain_backpressure();
    load_regs(32'h0);
    prep_switch(32'h1000, 32'h2000, 32'h0, 32'h200);
    run_switch(32'h1000, 32'h2000, 3, 32'h101C, 32'd7, 2, -1, -1, -1);
    total++; if (m_first_wr != 4) begin bad++; $display("FAIL drain_first_store got %0d expected 4", m_first_wr); end
    total++; if (m_stable != 3) begin bad++; $display("FAIL busy_stable got %0d cycles expected 3", m_stable); end
    total++; if (m_done_cyc != 68) begin bad++; $display("FAIL busy_latency got %0d expected 68", m_done_cyc); end
    total++; if (exp_st_a.size() != 0 || exp_rf_a.size() != 0) begin bad++; $display("FAIL busy_drained got %0d/%0d left expected 0/0", exp_st_a.size(), exp_rf_a.size()); end
  endtask

  task automatic test_collisions();
    load_regs(32'h40);
    prep_switch(32'h1000, 32'h2000, 32'h40, 32'h300);
    run_switch(32'h1000, 32'h2000, 0, 32'hFFFFFFFF, 32'h0, 0, 10, 40, 45);
    total++; if (m_n_done != 1) begin bad++; $display("FAIL coll_done_count got %0d expected 1", m_n_done); end
    total++; if (m_stall_after != 0) begin bad++; $display("FAIL coll_no_requeue got %0d stalled cycles expected 0", m_stall_after); end
    total++; if (exp_st_a.size() != 0 || exp_rf_a.size() != 0) begin bad++; $display("FAIL coll_drained got %0d/%0d left expected 0/0", exp_st_a.size(), exp_rf_a.size()); end
    total++; if (rf[2] !== 32'h302) begin bad++; $display("FAIL coll_x2 got %h expected 302", rf[2]); end
  endtask

  task automatic test_reset_mid_switch();
    bit found;
    int dones;
    load_regs(32'h0);
    prep_switch(32'h1000, 32'h2000, 32'h0, 32'h400);
    tick();
    cs_req = 1'b1; save_base = 32'h1000; restore_base = 32'h2000; pipe_empty = 1'b1;
    tick();
    cs_req = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (mem_read && mem_addr == 32'h2028) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL rst_reach_idx10 got timeout expected restore of x10"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (pipe_stall !== 1'b0 || cs_busy !== 1'b0) begin bad++; $display("FAIL rst_idle got stall=%b busy=%b expected 0/0", pipe_stall, cs_busy); end
    total++; if (mem_read !== 1'b0 || cs_done !== 1'b0) begin bad++; $display("FAIL rst_quiet got read=%b done=%b expected 0/0", mem_read, cs_done); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (cs_done) dones++; end
    total++; if (dones != 0) begin bad++; $display("FAIL rst_no_done got %0d expected 0", dones); end
    exp_st_a.delete(); exp_st_d.delete(); exp_rf_a.delete(); exp_rf_d.delete();
    load_regs(32'h80);
    prep_switch(32'h1000, 32'h2000, 32'h80, 32'h500);
    run_switch(32'h1000, 32'h2000, 0, 32'hFFFFFFFF, 32'h0, 0, -1, -1, -1);
    total++; if (m_done_cyc != 64 || m_n_done != 1) begin bad++; $display("FAIL rst_retry got done@%0d x%0d expected done@64 x1", m_done_cyc, m_n_done); end
    total++; if (exp_st_a.size() != 0 || exp_rf_a.size() != 0) begin bad++; $display("FAIL rst_retry_drained got %0d/%0d left expected 0/0", exp_st_a.size(), exp_rf_a.size()); end
  endtask

`ifdef CS_DIRTY_SKIP_EN
  task automatic test_dirty_skip();
    tick();
    pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'h333;
    tick();
    pipe_wr_addr = 5'd17; pipe_wr_data = 32'h1717;
    tick();
    pipe_wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      mem[(32'h2000 >> 2) + i] = 32'h600 + 32'(i);
      exp_rf_a.push_back(32'(i));
      exp_rf_d.push_back(32'h600 + 32'(i));
    end
    exp_st_a.push_back(32'h100C); exp_st_d.push_back(32'h333);
    exp_st_a.push_back(32'h1044); exp_st_d.push_back(32'h1717);
    run_switch(32'h1000, 32'h2000, 0, 32'hFFFFFFFF, 32'h0, 0, -1, -1, -1);
    total++; if (m_save_cyc != 31) begin bad++; $display("FAIL dirty_save_len got %0d expected 31", m_save_cyc); end
    total++; if (m_done_cyc != 64) begin bad++; $display("FAIL dirty_latency got %0d expected 64", m_done_cyc); end
    total++; if (exp_st_a.size() != 0 || exp_rf_a.size() != 0) begin bad++; $display("FAIL dirty_drained got %0d/%0d left expected 0/0", exp_st_a.size(), exp_rf_a.size()); end
  endtask
`endif

  initial begin
    reset = 1'b1; cs_req = 1'b0; pipe_empty = 1'b1; pipe_wr_en = 1'b0;
    pipe_wr_addr = 5'd0; pipe_wr_data = 32'h0; pipe_rd_addr = 5'd0;
    mem_busy = 1'b0; save_base = 32'h0; restore_base = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    test_reset();
    test_pass_through();
    test_full_switch();
    test_drain_backpressure();
    test_collisions();
    test_reset_mid_switch();
`ifdef CS_DIRTY_SKIP_EN
    test_dirty_skip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
